// File: rtl/vector_checker_if.sv
// Port bundle for vector_checker: vector-memory load, run control, DUT stimulus/response
// and run status. The checker attaches through the slave modport.
interface vector_checker_if #(
    parameter int NIN   = 3,
    parameter int NOUT  = 1,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [NIN+2*NOUT-1:0] wr_data;
    logic [AW:0]           num_vec;
    logic                  stop_on_err;
    logic                  start;
    logic [NIN-1:0]        dut_in;
    logic [NOUT-1:0]       dut_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           errors;
    logic [AW:0]           checked;
    logic [AW-1:0]         first_err_idx;
    logic [NOUT-1:0]       first_err_got;
    logic [1:0]            state_dbg;

    modport master (
        output wr_en, wr_addr, wr_data, num_vec, stop_on_err, start, dut_out,
        input  dut_in, busy, done, pass, errors, checked, first_err_idx, first_err_got,
        input  state_dbg
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, num_vec, stop_on_err, start, dut_out,
        output dut_in, busy, done, pass, errors, checked, first_err_idx, first_err_got,
        output state_dbg
    );
endinterface

// File: rtl/vector_checker.sv
// Stored-vector checker: replays {in, exp, care} vectors into an external DUT and compares
// its response LAT cycles later, keeping mismatch statistics for the run.
module vector_checker #(
    parameter int NIN   = 3,
    parameter int NOUT  = 1,
    parameter int DEPTH = 16,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    vector_checker_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = NIN + 2 * NOUT;

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE (busy=0);
    // done then stays high until the next accepted start, and pass is valid while done=1.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic            v;
        logic [AW-1:0]   idx;
        logic [NOUT-1:0] exp;
        logic [NOUT-1:0] care;
    } dl_t;

    state_t          state, state_nxt;
    logic [W-1:0]    mem [DEPTH];
    logic [W-1:0]    rd;
    logic [AW-1:0]   idx;
    logic [AW:0]     num_lat;
    logic            stop_lat;
    dl_t             dl [LAT+1];
    dl_t             cur;
    logic [LAT:0]    vbits;
    logic            behind;
    logic            busy, start_ok, last_issue, issue;
    logic            hit, stop_now;
    logic [NIN-1:0]  dut_in_q;
    logic            done_q;
    logic [15:0]     errors_q;
    logic [AW:0]     checked_q;
    logic [AW-1:0]   first_idx_q;
    logic [NOUT-1:0] first_got_q;

    assign rd  = mem[idx];
    assign cur = dl[LAT];

    for (genvar k = 0; k <= LAT; k++) begin : g_vbits
        assign vbits[k] = dl[k].v;
    end

    // Entries younger than the one at the compare stage; none left means the run is drained.
    if (LAT == 0) begin : g_behind0
        assign behind = 1'b0;
    end else begin : g_behindn
        assign behind = |vbits[LAT-1:0];
    end

    assign busy       = (state == RUN) || (state == DRAIN);
    assign start_ok   = bus.start && !busy;
    assign last_issue = ({1'b0, idx} == (num_lat - 1'b1));
    assign hit        = cur.v && (|((bus.dut_out ^ cur.exp) & cur.care));
    assign stop_now   = hit && stop_lat && (errors_q == 16'd0);
    assign issue      = (state == RUN) && !stop_now;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nxt = (bus.num_vec == '0) ? DONE : RUN;
            end
            RUN: begin
                if (stop_now || last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!stop_now && !behind) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            num_lat     <= '0;
            stop_lat    <= 1'b0;
            dut_in_q    <= '0;
            done_q      <= 1'b0;
            errors_q    <= '0;
            checked_q   <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                idx         <= '0;
                num_lat     <= bus.num_vec;
                stop_lat    <= bus.stop_on_err;
                done_q      <= (bus.num_vec == '0);
                errors_q    <= '0;
                checked_q   <= '0;
                first_idx_q <= '0;
                first_got_q <= '0;
            end else begin
                if (state == DRAIN && state_nxt == DONE) done_q <= 1'b1;
                if (cur.v) checked_q <= checked_q + 1'b1;
                if (hit) begin
                    if (errors_q != 16'hFFFF) errors_q <= errors_q + 1'b1;
                    if (errors_q == 16'd0) begin
                        first_idx_q <= cur.idx;
                        first_got_q <= bus.dut_out;
                    end
                end
            end
            if (issue) begin
                dut_in_q <= rd[W-1 -: NIN];
                idx      <= idx + 1'b1;
            end
        end
    end

    // Delay line aligning each vector's exp/care with the DUT response LAT cycles later.
    always_ff @(posedge clk) begin
        if (reset || stop_now) begin
            for (int k = 0; k <= LAT; k++) dl[k] <= '0;
        end else begin
            dl[0] <= issue ? dl_t'{1'b1, idx, rd[2*NOUT-1 -: NOUT], rd[NOUT-1:0]} : '0;
            for (int k = 1; k <= LAT; k++) dl[k] <= dl[k-1];
        end
    end

    // Vector memory survives reset; loading is only allowed while no run is in progress.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy) mem[bus.wr_addr] <= bus.wr_data;
    end

    assign bus.dut_in        = dut_in_q;
    assign bus.busy          = busy;
    assign bus.done          = done_q;
    assign bus.pass          = done_q && (errors_q == 16'd0);
    assign bus.errors        = errors_q;
    assign bus.checked       = checked_q;
    assign bus.first_err_idx = first_idx_q;
    assign bus.first_err_got = first_got_q;
    assign bus.state_dbg     = state;
endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 SHALL have parameter NIN, default 3: DUT input width in bits (1..32).
REQ-002 SHALL have parameter NOUT, default 1: DUT output width in bits (1..32).
REQ-003 SHALL have parameter DEPTH, default 16: vector memory entries (power of 2, >=2); AW = clog2(DEPTH).
REQ-004 SHALL have parameter LAT, default 0: DUT latency in clock cycles (0..7).
REQ-005 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-006 SHALL have ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
wr_en  in  1  vector memory write strobe
wr_addr  in  AW  write index
wr_data  in  NIN+2*NOUT  vector = {in, exp, care}; care bit 1 = compare this output bit
num_vec  in  AW+1  vectors to run (0..DEPTH), sampled with start
stop_on_err  in  1  mode, sampled with start
start  in  1  run request
dut_in  out  NIN  registered stimulus to DUT
dut_out  in  NOUT  DUT response
busy  out  1  run in progress
done  out  1  run finished, held until next accepted start
pass  out  1  done and errors == 0
errors  out  16  mismatch count, saturating
checked  out  AW+1  vectors compared
first_err_idx  out  AW  index of first mismatching vector
first_err_got  out  NOUT  dut_out captured at first mismatch

Function
REQ-007 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy = state is RUN or DRAIN.
REQ-008 SHALL write wr_data to mem[wr_addr] on an edge with wr_en=1 only when busy=0; writes while busy are dropped.
REQ-009 SHALL accept start only in IDLE or DONE: clear errors, checked, first_err_*, done; latch num_vec and stop_on_err; reset issue index to 0; enter RUN (or DONE directly with pass=1 if num_vec=0).
REQ-010 SHALL ignore start while busy.
REQ-011 In RUN, each edge SHALL load dut_in <= mem[idx].in, push {valid=1, exp, care} into a delay line, and increment idx; at the edge issuing idx = num_vec-1 the FSM SHALL enter DRAIN.
REQ-012 SHALL compare dut_out against the delay-line entry aligned LAT cycles after its dut_in update; mismatch = |((dut_out ^ exp) & care).
REQ-013 Each valid compare SHALL increment checked at the next edge; a mismatch SHALL also increment errors, saturating at 16'hFFFF.
REQ-014 On the first mismatch of a run, SHALL capture first_err_idx and first_err_got; later mismatches leave them unchanged.
REQ-015 Vector i result SHALL be registered at edge S+i+2+LAT, S = start-accept edge; done SHALL rise at edge S+num_vec+1+LAT when no stop occurs.
REQ-016 With stop_on_err=1, at the edge registering the first mismatch the FSM SHALL stop issuing, invalidate all in-flight delay-line entries, and enter DONE at the following edge.
REQ-017 dut_in SHALL hold its last value outside RUN.
REQ-018 A care mask of all zeros SHALL always count as a match.

Reset
REQ-019 reset SHALL force IDLE, dut_in=0, done=0, pass=0, busy=0, errors=0, checked=0, first_err_idx=0, first_err_got=0, and clear all delay-line valid bits, including mid-run.
REQ-020 Memory contents SHALL NOT be affected by reset.

Verification
REQ-021 NIN=3, NOUT=1, LAT=0, DUT y=~b&~c | a&~b&c, 8 vectors abc=000..111 with exp 1,0,0,0,1,1,0,0, care=1, start -> done at S+9, checked=8, errors=0, pass=1.
REQ-022 Same run, exp of vector 3 changed to 1, stop_on_err=0 -> checked=8, errors=1, first_err_idx=3, first_err_got=0, pass=0.
REQ-023 Same as REQ-022 with stop_on_err=1 -> issuing halts, done at S+6, checked=4, errors=1.
REQ-024 LAT=2 with DUT registered twice, 8 correct vectors -> done at S+11, errors=0; vector 3 with care=0 and wrong exp still counts as a match.
REQ-025 reset pulsed at S+4 of an 8-vector run -> next edge busy=0, checked=0, errors=0; new start with num_vec=0 -> done=1, pass=1 next edge; memory still holds the loaded vectors.
REQ-026 wr_en and start asserted during RUN -> memory unchanged and current run completes unaffected.
